// File: rtl/sub_nibble_serial.sv
// rtl/sub_nibble_serial.sv - nibble-serial W-bit subtractor d = x - y with start/done handshake
// Optional macro SUB_OVF_EN adds the signed-overflow output ovf_o.
module sub_nibble_serial #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] d_o,
   output logic         bo_o
`ifdef SUB_OVF_EN
   ,
   output logic         ovf_o
`endif
);
   localparam int N  = W / 4;
   localparam int CW = $clog2(N);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q;
   logic [W-1:0]  x_q, y_q, d_q;
   logic [CW-1:0] cnt_q;
   logic          borrow_q, busy_q, done_q, bo_q;
`ifdef SUB_OVF_EN
   logic          ovf_q;
`endif

   logic [CW+1:0] base;
   logic [3:0]    a, b, g, p, bc, diff;
   logic          bout, last;

   // One 4-bit borrow-lookahead slice on the nibble selected by cnt_q.
   always_comb begin
      base  = {cnt_q, 2'b00};
      a     = x_q[base +: 4];
      b     = y_q[base +: 4];
      g     = ~a & b;
      p     = ~(a ^ b);
      bc[0] = borrow_q;
      bc[1] = g[0] | (p[0] & borrow_q);
      bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_q);
      bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & borrow_q);
      bout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & borrow_q);
      diff  = a ^ b ^ bc;
      last  = (cnt_q == CW'(N - 1));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bo_q     <= 1'b0;
`ifdef SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  x_q      <= x_i;
                  y_q      <= y_i;
                  d_q      <= '0;
                  cnt_q    <= '0;
                  borrow_q <= 1'b0;
                  busy_q   <= 1'b1;
                  bo_q     <= 1'b0;
`ifdef SUB_OVF_EN
                  ovf_q    <= 1'b0;
`endif
                  state_q  <= RUN;
               end
            end
            RUN: begin
               d_q[base +: 4] <= diff;
               borrow_q       <= bout;
               if (last) begin
                  bo_q    <= bout;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`ifdef SUB_OVF_EN
                  ovf_q   <= (x_q[W-1] ^ y_q[W-1]) & (diff[3] ^ x_q[W-1]);
`endif
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign d_o    = d_q;
   assign bo_o   = bo_q;
`ifdef SUB_OVF_EN
   assign ovf_o  = ovf_q;
`endif

endmodule
